// File: rtl/cnn1d_pkg.sv
// Shared constants for the 1D CNN datapath and the pooling stage helpers.
package cnn1d_pkg;

  // Sample width carried on every stream of the datapath.
  localparam int DATA_WIDTH = 12;

  // Default window length of the pooling stage.
  localparam int POOL_SIZE_DEFAULT = 4;

  // Accumulator width that can hold pool_size full-scale samples without overflow.
  function automatic int pool_acc_width(input int pool_size);
    return DATA_WIDTH + $clog2(pool_size);
  endfunction

endpackage

// File: rtl/sum_pool.sv
// Windowed sum/average pooling: every POOL_SIZE accepted samples collapse
// into one output sample (saturated sum or floor mean) held in a single
// output register with valid/ready handshakes on both sides.
module sum_pool
  import cnn1d_pkg::*;
#(
  parameter int POOL_SIZE = POOL_SIZE_DEFAULT,
  parameter int AVERAGE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  pool_ready_in,
  input  logic [DATA_WIDTH-1:0] pool_data_in,
  input  logic                  pool_valid_in,
  input  logic                  pool_ready_out,
  output logic [DATA_WIDTH-1:0] pool_data_out,
  output logic                  pool_valid_out
);

  localparam int SHIFT           = $clog2(POOL_SIZE);
  localparam int ACC_W           = pool_acc_width(POOL_SIZE);
  localparam int CNT_W           = (SHIFT < 1) ? 1 : SHIFT;
  // Depth of the output stage, kept visible so bench timing can line up.
  localparam int POOL_PIPE_WIDTH = 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(POOL_SIZE - 1);

  // Window length must be a power of two so the mean is a plain shift.
  if ((POOL_SIZE < 2) || ((POOL_SIZE & (POOL_SIZE - 1)) != 0)) begin : g_bad_pool_size
    $fatal(1, "sum_pool: POOL_SIZE must be a power of two and >= 2");
  end

  logic [CNT_W-1:0]           r_cnt;
  logic [ACC_W-1:0]           r_acc;
  logic [DATA_WIDTH-1:0]      r_data_out;
  logic [POOL_PIPE_WIDTH-1:0] r_valid_out;

  logic                  w_last;
  logic                  w_accept;
  logic                  w_xfer;
  logic [ACC_W-1:0]      w_sum;
  logic [DATA_WIDTH-1:0] w_result;

  assign w_last        = (r_cnt == LAST_CNT);
  // Only the closing sample can stall, and only behind an undrained result.
  assign pool_ready_in = !rst && (!w_last || !r_valid_out[0] || pool_ready_out);
  assign w_accept      = pool_valid_in && pool_ready_in;
  assign w_xfer        = r_valid_out[0] && pool_ready_out;
  // The first sample of a window restarts the sum instead of adding to stale data.
  assign w_sum         = ((r_cnt == '0) ? '0 : r_acc) + ACC_W'(pool_data_in);

  if (AVERAGE != 0) begin : g_average
    // Floor mean: the top DATA_WIDTH bits of the full sum always fit.
    assign w_result = w_sum[SHIFT +: DATA_WIDTH];
  end else begin : g_sum
    // Clamp the sum to full scale when it exceeds the output width.
    assign w_result = (w_sum[ACC_W-1:DATA_WIDTH] != '0) ? {DATA_WIDTH{1'b1}}
                                                        : w_sum[DATA_WIDTH-1:0];
  end

  // Window counter and running sum advance on every accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Output register: load on the closing sample, drop valid once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out  <= '0;
      r_valid_out <= '0;
    end else if (w_accept && w_last) begin
      r_data_out  <= w_result;
      r_valid_out <= POOL_PIPE_WIDTH'(1);
    end else if (w_xfer) begin
      r_valid_out <= '0;
    end
  end

  assign pool_data_out  = r_data_out;
  assign pool_valid_out = r_valid_out[0];

endmodule

// File: tb/tb_sum_pool.sv
// Bench for sum_pool: a sum instance and a mean instance share one stimulus
// stream; a window-level model predicts handshakes and results each cycle.
module tb_sum_pool;
  import cnn1d_pkg::*;

  localparam int P    = POOL_SIZE_DEFAULT;
  localparam int SH   = $clog2(P);
  localparam int MAXV = (1 << DATA_WIDTH) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, v_in, rdy_out;
  logic [DATA_WIDTH-1:0] d_in;
  logic                  rdy0, rdy1, vo0, vo1;
  logic [DATA_WIDTH-1:0] do0, do1;

  sum_pool #(.POOL_SIZE(P), .AVERAGE(0)) dut0 (
    .clk(clk), .rst(rst), .pool_ready_in(rdy0), .pool_data_in(d_in),
    .pool_valid_in(v_in), .pool_ready_out(rdy_out),
    .pool_data_out(do0), .pool_valid_out(vo0));

  sum_pool #(.POOL_SIZE(P), .AVERAGE(1)) dut1 (
    .clk(clk), .rst(rst), .pool_ready_in(rdy1), .pool_data_in(d_in),
    .pool_valid_in(v_in), .pool_ready_out(rdy_out),
    .pool_data_out(do1), .pool_valid_out(vo1));

  int n_vec  = 0;
  int n_fail = 0;

  // Model: samples seen in the current window, their sum, and the held result.
  int m_cnt, m_sum, m_valid, m_data0, m_data1;
  int got0[$], got1[$], exp0[$], exp1[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sum = 0; m_valid = 0; m_data0 = 0; m_data1 = 0;
  endtask

  // One clock cycle: drive, check DUT against model, advance model, clock.
  task automatic step(input bit r, input bit v, input int d, input bit ro, output bit acc);
    bit m_ready, xfer, closed;
    @(negedge clk);
    rst = r; v_in = v; d_in = d[DATA_WIDTH-1:0]; rdy_out = ro;
    #1;
    m_ready = !r && ((m_cnt != P - 1) || (m_valid == 0) || ro);
    chk("ready_in_sum", int'(rdy0), int'(m_ready));
    chk("ready_in_avg", int'(rdy1), int'(m_ready));
    chk("valid_out_sum", int'(vo0), m_valid);
    chk("valid_out_avg", int'(vo1), m_valid);
    chk("data_out_sum", int'(do0), m_data0);
    chk("data_out_avg", int'(do1), m_data1);
    if (vo0 && ro) got0.push_back(int'(do0));
    if (vo1 && ro) got1.push_back(int'(do1));
    acc    = v && m_ready;
    xfer   = (m_valid != 0) && ro;
    closed = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      if (acc) begin
        m_sum += d;
        m_cnt++;
        if (m_cnt == P) begin
          closed  = 1'b1;
          m_data0 = (m_sum > MAXV) ? MAXV : m_sum;
          m_data1 = m_sum >> SH;
          exp0.push_back(m_data0);
          exp1.push_back(m_data1);
          m_valid = 1;
          m_cnt   = 0;
          m_sum   = 0;
        end
      end
      if (!closed && xfer) m_valid = 0;
    end
    @(posedge clk);
  endtask

  task automatic send(input int d, input bit ro);
    bit a;
    int tries;
    tries = 0;
    a = 1'b0;
    while (!a && tries < 40) begin
      step(1'b0, 1'b1, d, ro, a);
      tries++;
    end
    if (!a) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: sample %0d not accepted within 40 cycles", d);
    end
  endtask

  task automatic idle(input int n, input bit ro);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, ro, a);
  endtask

  task automatic check_list(input string name, input int q[$], input int e[$]);
    chk({name, "_count"}, q.size(), e.size());
    for (int i = 0; i < q.size() && i < e.size(); i++) chk(name, q[i], e[i]);
  endtask

  task automatic clear_lists();
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
  endtask

  initial begin
    bit a;
    int e0[$], e1[$];
    rst = 1'b1; v_in = 1'b0; d_in = '0; rdy_out = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1'b1, 1'b1, 5, 1'b1, a);   // in reset: not ready, outputs cleared

    // Sum and mean of a cubic sequence, back to back.
    clear_lists();
    send(1, 1'b1); send(8, 1'b1); send(27, 1'b1); send(64, 1'b1);
    idle(2, 1'b1);
    e0 = {100}; e1 = {25};
    check_list("seq_cubes_sum", got0, e0);
    check_list("seq_cubes_avg", got1, e1);

    // Floor in the mean: 41 >> 2 = 10.
    clear_lists();
    send(4, 1'b1); send(8, 1'b1); send(12, 1'b1); send(17, 1'b1);
    idle(2, 1'b1);
    e0 = {41}; e1 = {10};
    check_list("floor_sum", got0, e0);
    check_list("floor_avg", got1, e1);

    // Full-scale inputs: sum saturates, mean stays exact.
    clear_lists();
    for (int i = 0; i < P; i++) send(MAXV, 1'b1);
    idle(2, 1'b1);
    e0 = {4095}; e1 = {4095};
    check_list("saturate_sum", got0, e0);
    check_list("saturate_avg", got1, e1);

    // Backpressure: second window's closing sample stalls behind held result.
    clear_lists();
    for (int i = 0; i < P; i++) send(1, 1'b0);
    for (int i = 0; i < P - 1; i++) send(2, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2, 1'b0, a);
    step(1'b0, 1'b1, 2, 1'b1, a);   // closing accept and transfer on one edge
    step(1'b0, 1'b0, 0, 1'b1, a);
    idle(1, 1'b1);
    e0 = {4, 8}; e1 = {1, 2};
    check_list("backpressure_sum", got0, e0);
    check_list("backpressure_avg", got1, e1);

    // Reset mid-window discards the partial sum.
    clear_lists();
    send(9, 1'b1); send(9, 1'b1);
    step(1'b1, 1'b0, 0, 1'b1, a);
    step(1'b1, 1'b0, 0, 1'b1, a);
    for (int i = 0; i < P; i++) send(1, 1'b1);
    idle(2, 1'b1);
    e0 = {4}; e1 = {1};
    check_list("reset_window_sum", got0, e0);
    check_list("reset_window_avg", got1, e1);

    // Randomized traffic on both handshakes, scoreboarded in order.
    clear_lists();
    for (int i = 0; i < 2000; i++)
      step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 64)),
           1'($urandom_range(0, 1)), a);
    idle(4, 1'b1);
    check_list("random_sum", got0, exp0);
    check_list("random_avg", got1, exp1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
